// File: rtl/alu_z_stage_if.sv
// Handshake bundle between the ALU, the Z result stage and the result bus.
// The stage is the slave; the ALU/bus environment drives the master side.
interface alu_z_stage_if #(
    parameter int WORD_SIZE = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WORD_SIZE-1:0] in_lo;
    logic [WORD_SIZE-1:0] in_hi;
    logic                 in_wide;
    logic                 in_carry;
    logic                 out_valid;
    logic                 out_ready;
    logic [WORD_SIZE-1:0] out_data;
    logic                 out_sel;
    logic                 out_last;

    modport master (
        output in_valid, in_lo, in_hi, in_wide, in_carry, out_ready,
        input  in_ready, out_valid, out_data, out_sel, out_last
    );

    modport slave (
        input  in_valid, in_lo, in_hi, in_wide, in_carry, out_ready,
        output in_ready, out_valid, out_data, out_sel, out_last
    );
endinterface

// File: rtl/alu_z_stage.sv
// Z result stage: latches an ALU result and drains it as ZLO then ZHI beats.
// Define ALU_Z_FLAGS_EN to add registered zero_flag/neg_flag outputs.
module alu_z_stage #(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_z_stage_if.slave         bus,
    output logic [WORD_SIZE-1:0] z_lo,
    output logic [WORD_SIZE-1:0] z_hi,
    output logic                 carry_flag,
`ifdef ALU_Z_FLAGS_EN
    output logic                 zero_flag,
    output logic                 neg_flag,
`endif
    output logic                 busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } state_t;

    state_t state;
    state_t nxt;
    logic   wide;
    logic   accept;
    logic   fin;

    assign bus.out_valid = (state != IDLE);
    assign bus.out_sel   = (state == HI);
    assign bus.out_last  = (state == HI) | ((state == LO) & ~wide);
    assign bus.out_data  = (state == LO) ? z_lo :
                           (state == HI) ? z_hi : '0;
    assign busy          = (state != IDLE);

    // Final-beat handshake frees the register pair in the same edge.
    assign fin          = bus.out_valid & bus.out_last & bus.out_ready;
    assign bus.in_ready = (state == IDLE) | fin;
    assign accept       = bus.in_valid & bus.in_ready;

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: if (accept) nxt = LO;
            LO: begin
                if (bus.out_ready) begin
                    if (wide)        nxt = HI;
                    else if (accept) nxt = LO;
                    else             nxt = IDLE;
                end
            end
            HI: begin
                if (bus.out_ready) nxt = accept ? LO : IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            z_lo       <= '0;
            z_hi       <= '0;
            wide       <= 1'b0;
            carry_flag <= 1'b0;
        end else begin
            state <= nxt;
            if (accept) begin
                z_lo       <= bus.in_lo;
                z_hi       <= bus.in_wide ? bus.in_hi : '0;
                wide       <= bus.in_wide;
                carry_flag <= bus.in_carry;
            end
        end
    end

`ifdef ALU_Z_FLAGS_EN
    logic zero_d;
    logic neg_d;

    assign zero_d = (bus.in_lo == '0) & (~bus.in_wide | (bus.in_hi == '0));
    assign neg_d  = bus.in_wide ? bus.in_hi[WORD_SIZE-1]
                                : bus.in_lo[WORD_SIZE-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero_flag <= 1'b0;
            neg_flag  <= 1'b0;
        end else if (accept) begin
            zero_flag <= zero_d;
            neg_flag  <= neg_d;
        end
    end
`endif
endmodule

// File: tb/tb_alu_z_stage.sv
// Bench for alu_z_stage: directed scenarios then random traffic,
// checked against a beat-queue reference model.
module tb_alu_z_stage;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic [W-1:0] z_lo;
    logic [W-1:0] z_hi;
    logic carry_flag;
    logic busy;
`ifdef ALU_Z_FLAGS_EN
    logic zero_flag;
    logic neg_flag;
`endif

    alu_z_stage_if #(.WORD_SIZE(W)) bus ();

    alu_z_stage #(.WORD_SIZE(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .z_lo       (z_lo),
        .z_hi       (z_hi),
        .carry_flag (carry_flag),
`ifdef ALU_Z_FLAGS_EN
        .zero_flag  (zero_flag),
        .neg_flag   (neg_flag),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        logic         sel;
        logic         last;
    } beat_t;

    beat_t        q[$];
    logic [W-1:0] m_lo;
    logic [W-1:0] m_hi;
    logic         m_carry;
    logic         m_zero;
    logic         m_neg;
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_lo = '0;
        m_hi = '0;
        m_carry = 1'b0;
        m_zero = 1'b0;
        m_neg = 1'b0;
    endtask

    task automatic check_regs();
        chk("z_lo", z_lo, m_lo);
        chk("z_hi", z_hi, m_hi);
        chk("carry_flag", carry_flag, m_carry);
`ifdef ALU_Z_FLAGS_EN
        chk("zero_flag", zero_flag, m_zero);
        chk("neg_flag", neg_flag, m_neg);
`endif
    endtask

    // One clock: drive, check all outputs against the model, advance model.
    task automatic cycle(input logic v, input logic [W-1:0] lo,
                         input logic [W-1:0] hi, input logic wd,
                         input logic cy, input logic ordy);
        logic  e_valid;
        logic  e_ready;
        beat_t h;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_lo     = lo;
        bus.in_hi     = hi;
        bus.in_wide   = wd;
        bus.in_carry  = cy;
        bus.out_ready = ordy;
        #1;
        e_valid = (q.size() != 0);
        h = '{data: '0, sel: 1'b0, last: 1'b0};
        if (e_valid) h = q[0];
        // Stage holds one result; it frees when its last beat leaves.
        e_ready = !e_valid || (q.size() == 1 && ordy);
        chk("out_valid", bus.out_valid, e_valid);
        chk("out_data", bus.out_data, h.data);
        chk("out_sel", bus.out_sel, h.sel);
        chk("out_last", bus.out_last, h.last);
        chk("in_ready", bus.in_ready, e_ready);
        chk("busy", busy, e_valid);
        check_regs();
        @(posedge clk);
        if (e_valid && ordy) void'(q.pop_front());
        if (v && e_ready) begin
            q.push_back('{data: lo, sel: 1'b0, last: !wd});
            if (wd) q.push_back('{data: hi, sel: 1'b1, last: 1'b1});
            m_lo = lo;
            m_hi = wd ? hi : '0;
            m_carry = cy;
            m_zero = (lo == 0) && (!wd || hi == 0);
            m_neg = wd ? (hi >= 32'h8000_0000) : (lo >= 32'h8000_0000);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst out_valid", bus.out_valid, 1'b0);
        chk("rst out_sel", bus.out_sel, 1'b0);
        chk("rst out_last", bus.out_last, 1'b0);
        chk("rst out_data", bus.out_data, '0);
        chk("rst busy", busy, 1'b0);
        chk("rst in_ready", bus.in_ready, 1'b1);
        check_regs();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_lo = '0;
        bus.in_hi = '0;
        bus.in_wide = 1'b0;
        bus.in_carry = 1'b0;
        bus.out_ready = 1'b0;
        model_clear();
        do_reset();

        // Reset while the ZHI beat is stalled.
        cycle(1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1, 1, 0);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0);
        chk("midhi sel", bus.out_sel, 1'b1);
        do_reset();

        // Narrow result of 7.
        cycle(1, 32'h7, 32'hFFFF_FFFF, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);

        // Wide result, two beats.
        cycle(1, 32'h89AB_CDEF, 32'h0123_4567, 1, 1, 1);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);

        // Back-to-back narrow results 1..4.
        for (int i = 1; i <= 4; i++)
            cycle(1, W'(i), 0, 0, i[0], 1);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);

        // Backpressure on ZLO with a competing input.
        cycle(1, 32'h5555_AAAA, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++)
            cycle(1, 32'h1234_0000 + W'(i), 32'h1, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);

        // Flag cases: narrow zero, wide negative high word.
        cycle(1, 32'h0, 32'h1234_5678, 0, 1, 1);
        cycle(1, 32'h0, 32'h8000_0000, 1, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 7) == 0) ? '0 : W'($urandom),
                  ($urandom_range(0, 3) == 0) ? '0 : W'($urandom),
                  1'($urandom), 1'($urandom),
                  $urandom_range(0, 3) != 0);
            if (i == 200) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
